// File: rtl/mult_if.sv
// Handshake and operand/result bundle between the control unit (master) and the multiplier (slave).
// The is_unsigned signal exists only when MULT_UNSIGNED_EN is defined.
interface mult_if;
  logic        mult_start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
`ifdef MULT_UNSIGNED_EN
  logic        is_unsigned;
`endif
  logic        mult_busy;
  logic        mult_end;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
`ifdef MULT_UNSIGNED_EN
    output is_unsigned,
`endif
    output mult_start,
    output multiplicand,
    output multiplier,
    input  mult_busy,
    input  mult_end,
    input  hi,
    input  lo
  );

  modport slave (
`ifdef MULT_UNSIGNED_EN
    input  is_unsigned,
`endif
    input  mult_start,
    input  multiplicand,
    input  multiplier,
    output mult_busy,
    output mult_end,
    output hi,
    output lo
  );
endinterface

// File: rtl/mult.sv
// Sequential 32x32 radix-2 Booth multiplier for HI/LO, one step per falling clock edge.
// Define MULT_UNSIGNED_EN to add the is_unsigned input (multu support).
module mult (
  input  logic  clk,
  input  logic  rst,
  mult_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]  state;
  logic [5:0]  cnt;
  logic [32:0] acc;
  logic [32:0] q;
  logic        q_m1;
  logic [32:0] m;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        end_q;

  logic        sign_ext;
  logic [32:0] a_ext;
  logic [32:0] b_ext;
  logic [32:0] acc_op;
  logic [66:0] shifted;

  // Zero-extension for multu only; the mode is consumed at the start edge.
  always_comb begin
`ifdef MULT_UNSIGNED_EN
    sign_ext = ~bus.is_unsigned;
`else
    sign_ext = 1'b1;
`endif
    a_ext = {sign_ext & bus.multiplicand[31], bus.multiplicand};
    b_ext = {sign_ext & bus.multiplier[31], bus.multiplier};
  end

  always_comb begin
    acc_op = acc;
    case ({q[0], q_m1})
      2'b01:   acc_op = acc + m;
      2'b10:   acc_op = acc - m;
      default: acc_op = acc;
    endcase
  end

  // Arithmetic shift of {acc_op, q, q_m1}; bits [64:1] are the low 64 product bits.
  assign shifted = {acc_op[32], acc_op, q};

  always_ff @(negedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 6'd0;
      acc   <= 33'd0;
      q     <= 33'd0;
      q_m1  <= 1'b0;
      m     <= 33'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
      end_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.mult_start) begin
            acc   <= 33'd0;
            q     <= b_ext;
            q_m1  <= 1'b0;
            m     <= a_ext;
            cnt   <= 6'd33;
            end_q <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          acc  <= shifted[66:34];
          q    <= shifted[33:1];
          q_m1 <= shifted[0];
          cnt  <= cnt - 6'd1;
          if (cnt == 6'd1) begin
            hi_q  <= shifted[64:33];
            lo_q  <= shifted[32:1];
            end_q <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mult_busy = (state == RUN);
  assign bus.mult_end  = end_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule

// File: tb/tb_mult.sv
// Directed self-checking bench for mult; state changes on falling edges, so sampling is #1 after them.
// Unsigned-mode vectors are exercised only when MULT_UNSIGNED_EN is defined.
module tb_mult;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   edges;
  logic busy_ok;

  mult_if bus ();

  mult dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives operands with start high across one falling edge (E0), then drops start.
  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic u);
    bus.multiplicand = a;
    bus.multiplier   = b;
`ifdef MULT_UNSIGNED_EN
    bus.is_unsigned  = u;
`else
    if (u) $display("[TB] note: unsigned request ignored in signed-only build");
`endif
    bus.mult_start   = 1'b1;
    tick();
    bus.mult_start   = 1'b0;
  endtask

  // Counts edges until mult_end, bounded so a stuck DUT still reaches the summary.
  task automatic wait_done(input int already);
    edges   = already;
    busy_ok = 1'b1;
    while (edges < 45) begin
      tick();
      edges++;
      if (bus.mult_end === 1'b1) break;
      if (bus.mult_busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic run_and_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic u, input logic [63:0] product);
    apply_stimulus(a, b, u);
    check_output({tag, "_busy_e0"}, {63'd0, bus.mult_busy}, 64'd1);
    wait_done(0);
    check_output({tag, "_latency"}, 64'(edges), 64'd33);
    check_output({tag, "_busy_run"}, {63'd0, busy_ok}, 64'd1);
    check_output({tag, "_busy_after"}, {63'd0, bus.mult_busy}, 64'd0);
    check_output({tag, "_product"}, {bus.hi, bus.lo}, product);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.mult_start   = 1'b0;
    bus.multiplicand = 32'd0;
    bus.multiplier   = 32'd0;
`ifdef MULT_UNSIGNED_EN
    bus.is_unsigned  = 1'b0;
`endif
    tick();
    tick();
    check_output("reset_hi_lo", {bus.hi, bus.lo}, 64'd0);
    check_output("reset_end", {63'd0, bus.mult_end}, 64'd0);
    check_output("reset_busy", {63'd0, bus.mult_busy}, 64'd0);

    // Reset and start on the same edge: reset wins.
    bus.mult_start = 1'b1;
    tick();
    bus.mult_start = 1'b0;
    check_output("rst_beats_start", {63'd0, bus.mult_busy}, 64'd0);
    rst = 1'b0;
    tick();
    check_output("idle_no_start", {63'd0, bus.mult_busy}, 64'd0);

    run_and_check("small", 32'd7, 32'd6, 1'b0, 64'd42);
    check_output("small_end", {63'd0, bus.mult_end}, 64'd1);
    tick();
    tick();
    tick();
    check_output("end_sticky", {63'd0, bus.mult_end}, 64'd1);
    check_output("result_hold", {bus.hi, bus.lo}, 64'd42);

    run_and_check("mixed", 32'hFFFF_FFFD, 32'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFF1);
    run_and_check("minmin", 32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000);
    run_and_check("maxmin", 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 64'hC000_0000_8000_0000);
    run_and_check("neg1sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'd1);
`ifdef MULT_UNSIGNED_EN
    run_and_check("unsigned", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001);
    run_and_check("unsigned_off", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'd1);
`endif

    // Start during RUN is ignored; operands may change after E0.
    apply_stimulus(32'd7, 32'd6, 1'b0);
    check_output("b2b_end_drop", {63'd0, bus.mult_end}, 64'd0);
    repeat (9) tick();
    bus.multiplicand = 32'd2;
    bus.multiplier   = 32'd2;
    bus.mult_start   = 1'b1;
    tick();
    bus.mult_start   = 1'b0;
    wait_done(10);
    check_output("ignore_latency", 64'(edges), 64'd33);
    check_output("ignore_product", {bus.hi, bus.lo}, 64'd42);

    // Back-to-back start on E34.
    apply_stimulus(32'd2, 32'd2, 1'b0);
    check_output("e34_end_low", {63'd0, bus.mult_end}, 64'd0);
    check_output("e34_busy", {63'd0, bus.mult_busy}, 64'd1);
    check_output("e34_hold_old", {bus.hi, bus.lo}, 64'd42);
    wait_done(0);
    check_output("e67_latency", 64'(edges), 64'd33);
    check_output("e67_product", {bus.hi, bus.lo}, 64'd4);

    // Reset mid-operation at E15.
    apply_stimulus(32'd7, 32'd6, 1'b0);
    repeat (14) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("midrst_busy", {63'd0, bus.mult_busy}, 64'd0);
    check_output("midrst_end", {63'd0, bus.mult_end}, 64'd0);
    check_output("midrst_hi_lo", {bus.hi, bus.lo}, 64'd0);
    run_and_check("after_rst", 32'd3, 32'd3, 1'b0, 64'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult.md
# mult

Sequential signed 32x32 multiplier for the MIPS datapath: the multiply counterpart of the iterative divider. It serves `mult` (and, when configured, `multu`) and writes a 64-bit product into the HI/LO pair. It uses radix-2 Booth recoding on 33-bit extended operands, one recoding step per clock, with a start/end handshake toward the control unit.

## Interface
- No parameters. Operand width is fixed at 32 bits.
- `clk` input 1: clock. All state updates occur on the falling edge.
- `rst` input 1: reset, synchronous, active-high.
- `mult_start` input 1: request a multiply. Sampled only in IDLE.
- `multiplicand` input 32: operand A. Captured at the start edge.
- `multiplier` input 32: operand B. Captured at the start edge.
- `is_unsigned` input 1: selects `multu`. This port exists only with `MULT_UNSIGNED_EN`.
- `mult_busy` output 1: high while in RUN.
- `mult_end` output 1: result valid. Sticky until the next accepted start or reset.
- `hi` output 32: product bits [63:32].
- `lo` output 32: product bits [31:0].

## Operation
- **States:** IDLE and RUN, held in a 1-bit state register, plus a 6-bit iteration counter `cnt`.
- **Operand extension:** both operands are extended to 33 bits.
  - Signed (`is_unsigned`=0, or the port is absent): sign-extend.
  - Unsigned: zero-extend.
- **Working register:** 67 bits, laid out as {acc[32:0], q[32:0], q_m1}.
- **IDLE, `mult_start`=1:**
  - acc←0, q←ext(multiplier), q_m1←0, m←ext(multiplicand), cnt←33.
  - `mult_end`←0, state←RUN.
- **IDLE, `mult_start`=0:** hold all state.
- **RUN, one step per edge:**
  - {q[0],q_m1}=01: acc←acc+m.
  - {q[0],q_m1}=10: acc←acc−m.
  - 00 or 11: no add or subtract.
  - Then arithmetic-shift the whole 67-bit register right by 1; acc[32] is replicated.
  - Then cnt←cnt−1.
- **Final step (cnt=1 at the edge):**
  - Perform the step, then write {hi,lo}←bits [63:0] of the post-shift {acc,q}.
  - `mult_end`←1, state←IDLE.
- **Width rules:**
  - The add and subtract are 33-bit two's-complement, and carry-out is discarded.
  - The 66-bit product is truncated to its low 64 bits, which is exact for 33-bit extended operands.
- `mult_start` while in RUN is ignored, with no queuing or restart.
- Operand inputs may change freely after the start edge; only the captured values are used.
- `hi`/`lo` hold their last result until the next completion. They are not cleared at start.
- **Reset (any state, including mid-operation):**
  - state←IDLE, cnt←0.
  - `hi`←0, `lo`←0, `mult_end`←0, `mult_busy`←0.
  - Any partial product is discarded.

## Timing
- The start edge is E0. Iterations run on edges E1..E33.
- On E33, `hi`/`lo` are written and `mult_end` rises. Latency is 33 clocks from the start edge to a valid result.
- `mult_busy` is high from E0 through E33 and low after E33.
- A new start is accepted on E34 at the earliest, so back-to-back throughput is one multiply per 34 clocks.
- `mult_end` falls on the edge that accepts the next start.
- If `rst` and `mult_start` are high on the same edge, reset wins and no operation starts.
- **Reset values:** `hi`=0, `lo`=0, `mult_end`=0, `mult_busy`=0.

## Configuration
- **`MULT_UNSIGNED_EN` defined:**
  - The `is_unsigned` port exists.
  - `is_unsigned`=1 at the start edge selects zero-extension of both operands, i.e. a `multu` result.
  - The mode is latched at start.
- **`MULT_UNSIGNED_EN` undefined:**
  - The port is absent.
  - Both operands are always sign-extended, so only `mult` semantics are available.
- Latency and handshake are identical in both builds.

## Test plan
- **Small signed:** A=7, B=6, pulse start → `mult_busy` high for E0..E33; at E33 `mult_end`=1, `hi`=0x00000000, `lo`=0x0000002A.
- **Mixed sign:** A=−3 (0xFFFFFFFD), B=5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- **Extreme operands:**
  - A=B=0x80000000 → `hi`=0x40000000, `lo`=0x00000000.
  - A=0x7FFFFFFF, B=0x80000000 → `hi`=0xC0000000, `lo`=0x80000000.
- **Unsigned mode (`MULT_UNSIGNED_EN`):** A=B=0xFFFFFFFF.
  - `is_unsigned`=1 → `hi`=0xFFFFFFFE, `lo`=0x00000001.
  - `is_unsigned`=0 → `hi`=0x00000000, `lo`=0x00000001.
- **Busy ignore and back-to-back:**
  - Start 7×6, then re-pulse start with A=2, B=2 at E10 → result is still 42 at E33.
  - Then start 2×2 at E34 → `mult_end` drops at E34 and `lo`=4 at E67.
- **Reset mid-operation:**
  - Assert `rst` at E15 of 7×6 → next edge shows `mult_busy`=0, `mult_end`=0, `hi`=`lo`=0.
  - A fresh start of 3×3 afterwards → `lo`=9 after 33 clocks.
